cdc_handshake_tx: RTL and testbench

//   Source-side (sending) end of a two-phase toggle req/ack handshake. It moves a multi-bit word

---
 rtl/cdc_handshake_tx_if.sv | 33 +++
 rtl/cdc_handshake_tx.sv | 95 +++++++++
 tb/tb_cdc_handshake_tx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cdc_handshake_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx_if
// Description : Upstream word port plus toggle req/ack crossing for cdc_handshake_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdc_handshake_tx_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   valid_in;
  logic                   ready_out;
  logic [DATA_WIDTH-1:0]  xfer_data_src_clk;
  logic                   xfer_req_src_clk;
  logic                   xfer_ack_dest_clk;
  logic                   done_out;
  logic [COUNT_WIDTH-1:0] xfer_count;
  logic                   proto_err;

  // Sender side of the crossing.
  modport slave (
    input  data_in, valid_in, xfer_ack_dest_clk,
    output ready_out, xfer_data_src_clk, xfer_req_src_clk, done_out, xfer_count, proto_err
  );

  // Upstream producer together with the destination endpoint.
  modport master (
    output data_in, valid_in, xfer_ack_dest_clk,
    input  ready_out, xfer_data_src_clk, xfer_req_src_clk, done_out, xfer_count, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx
// Description : Source end of a two-phase toggle req/ack word crossing.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  wire logic          src_clk,
  input  wire logic          rst,
  cdc_handshake_tx_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   req_q, req_d;
  logic                   ack_s1_q, ack_s2_q, ack_prev_q;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] xfer_count_q, xfer_count_d;
  logic                   proto_err_q, proto_err_d;
  logic                   ready;

  assign ready = (state_q == ST_IDLE) && !rst;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    req_d        = req_q;
    done_d       = 1'b0;
    xfer_count_d = xfer_count_q;
    proto_err_d  = proto_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_in && ready) begin
          data_d  = bus.data_in;
          req_d   = ~req_q;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Ack has caught up with our request toggle: transfer complete.
        if (ack_s2_q == req_q) begin
          state_d      = ST_IDLE;
          done_d       = 1'b1;
          xfer_count_d = xfer_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Any ack edge while nothing is outstanding means the two ends disagree.
    if ((state_q == ST_IDLE) && (ack_s2_q != ack_prev_q)) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      req_q        <= 1'b0;
      ack_s1_q     <= 1'b0;
      ack_s2_q     <= 1'b0;
      ack_prev_q   <= 1'b0;
      done_q       <= 1'b0;
      xfer_count_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      req_q        <= req_d;
      ack_s1_q     <= bus.xfer_ack_dest_clk;
      ack_s2_q     <= ack_s1_q;
      ack_prev_q   <= ack_s2_q;
      done_q       <= done_d;
      xfer_count_q <= xfer_count_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign bus.ready_out         = ready;
  assign bus.xfer_data_src_clk = data_q;
  assign bus.xfer_req_src_clk  = req_q;
  assign bus.done_out          = done_q;
  assign bus.xfer_count        = xfer_count_q;
  assign bus.proto_err         = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_handshake_tx
// Description : Directed bench for cdc_handshake_tx with a simple destination ack model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cdc_handshake_tx;

  logic src_clk = 1'b0;
  logic rst     = 1'b1;
  logic ack_man  = 1'b0;
  logic auto_ack = 1'b0;
  logic ack_auto;
  int   tests = 0;
  int   fails = 0;

  cdc_handshake_tx_if #(.DATA_WIDTH(16), .COUNT_WIDTH(16)) bus ();

  cdc_handshake_tx #(.DATA_WIDTH(16), .COUNT_WIDTH(16)) dut (
    .src_clk (src_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 src_clk = ~src_clk;

  // Destination model: ack follows req one cycle later when auto mode is on.
  always @(posedge src_clk) ack_auto <= rst ? 1'b0 : bus.xfer_req_src_clk;
  assign bus.xfer_ack_dest_clk = auto_ack ? ack_auto : ack_man;

  task automatic cyc();
    @(posedge src_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; auto_ack = 1'b0; ack_man = 1'b0;
    bus.valid_in = 1'b0; bus.data_in = 16'h0000;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack_man = 1'b0; auto_ack = 1'b0;
    bus.valid_in = 1'b0; bus.data_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++; if (bus.ready_out !== 1'b0) begin fails++; $display("FAIL reset_ready_during cyc%0d: got %b want 0", i, bus.ready_out); end
      tests++; if (bus.xfer_req_src_clk !== 1'b0) begin fails++; $display("FAIL reset_req_during cyc%0d: got %b want 0", i, bus.xfer_req_src_clk); end
    end
    rst = 1'b0;
    #1;
    tests++; if (bus.ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", bus.ready_out); end
    tests++; if (bus.xfer_count !== 16'h0000) begin fails++; $display("FAIL reset_count: got %h want 0000", bus.xfer_count); end
    tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err: got %b want 0", bus.proto_err); end
    tests++; if (bus.done_out !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done_out); end
    tests++; if (bus.xfer_data_src_clk !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h want 0000", bus.xfer_data_src_clk); end
  endtask

  task automatic test_single();
    do_reset();
    bus.data_in = 16'hBEEF; bus.valid_in = 1'b1;
    cyc();
    bus.valid_in = 1'b0;
    tests++; if (bus.xfer_req_src_clk !== 1'b1) begin fails++; $display("FAIL single_req: got %b want 1", bus.xfer_req_src_clk); end
    tests++; if (bus.xfer_data_src_clk !== 16'hBEEF) begin fails++; $display("FAIL single_data: got %h want beef", bus.xfer_data_src_clk); end
    tests++; if (bus.ready_out !== 1'b0) begin fails++; $display("FAIL single_ready_busy: got %b want 0", bus.ready_out); end
    ack_man = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i < 3) begin
        tests++; if (bus.done_out !== 1'b0) begin fails++; $display("FAIL single_done_early edge%0d: got %b want 0", i, bus.done_out); end
      end else begin
        tests++; if (bus.done_out !== 1'b1) begin fails++; $display("FAIL single_done_edge3: got %b want 1", bus.done_out); end
        tests++; if (bus.xfer_count !== 16'h0001) begin fails++; $display("FAIL single_count: got %h want 0001", bus.xfer_count); end
        tests++; if (bus.ready_out !== 1'b1) begin fails++; $display("FAIL single_ready_with_done: got %b want 1", bus.ready_out); end
      end
    end
    cyc();
    tests++; if (bus.done_out !== 1'b0) begin fails++; $display("FAIL single_done_pulse_width: got %b want 0", bus.done_out); end
    tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL single_proto_err: got %b want 0", bus.proto_err); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic        exp_req;
    logic        accept;
    int          idx;
    int          dones;
    words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0003;
    do_reset();
    auto_ack = 1'b1;
    exp_req = 1'b0; idx = 0; dones = 0;
    bus.data_in = words[0]; bus.valid_in = 1'b1;
    for (int c = 0; c < 60 && dones < 3; c++) begin
      accept = bus.ready_out && bus.valid_in;
      cyc();
      if (bus.done_out === 1'b1) begin
        dones++;
        tests++; if (bus.ready_out !== 1'b1) begin fails++; $display("FAIL b2b_ready_with_done: got %b want 1", bus.ready_out); end
      end
      if (accept) begin
        exp_req = ~exp_req;
        tests++; if (bus.xfer_req_src_clk !== exp_req) begin fails++; $display("FAIL b2b_req word%0d: got %b want %b", idx, bus.xfer_req_src_clk, exp_req); end
        tests++; if (bus.xfer_data_src_clk !== words[idx]) begin fails++; $display("FAIL b2b_data word%0d: got %h want %h", idx, bus.xfer_data_src_clk, words[idx]); end
        idx++;
        if (idx < 3) bus.data_in = words[idx];
        else bus.valid_in = 1'b0;
      end else if (idx > 0) begin
        tests++; if (bus.xfer_data_src_clk !== words[idx-1]) begin fails++; $display("FAIL b2b_data_stable word%0d: got %h want %h", idx-1, bus.xfer_data_src_clk, words[idx-1]); end
        tests++; if (bus.xfer_req_src_clk !== exp_req) begin fails++; $display("FAIL b2b_req_stable word%0d: got %b want %b", idx-1, bus.xfer_req_src_clk, exp_req); end
      end
    end
    bus.valid_in = 1'b0;
    tests++; if (dones != 3) begin fails++; $display("FAIL b2b_done_count: got %0d want 3", dones); end
    tests++; if (idx != 3) begin fails++; $display("FAIL b2b_accept_count: got %0d want 3", idx); end
    tests++; if (bus.xfer_count !== 16'h0003) begin fails++; $display("FAIL b2b_count: got %h want 0003", bus.xfer_count); end
    tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL b2b_proto_err: got %b want 0", bus.proto_err); end
  endtask

  task automatic test_stall();
    do_reset();
    bus.data_in = 16'h1234; bus.valid_in = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      bus.data_in = 16'hAAA0 + 16'(i);
      cyc();
      tests++; if (bus.xfer_data_src_clk !== 16'h1234) begin fails++; $display("FAIL stall_data cyc%0d: got %h want 1234", i, bus.xfer_data_src_clk); end
      tests++; if (bus.xfer_req_src_clk !== 1'b1) begin fails++; $display("FAIL stall_req cyc%0d: got %b want 1", i, bus.xfer_req_src_clk); end
      tests++; if (bus.ready_out !== 1'b0) begin fails++; $display("FAIL stall_ready cyc%0d: got %b want 0", i, bus.ready_out); end
    end
    ack_man = 1'b1; bus.data_in = 16'h5555;
    repeat (3) cyc();
    bus.valid_in = 1'b0;
    tests++; if (bus.done_out !== 1'b1) begin fails++; $display("FAIL stall_done: got %b want 1", bus.done_out); end
    tests++; if (bus.xfer_req_src_clk !== 1'b1) begin fails++; $display("FAIL stall_no_accept_on_match_req: got %b want 1", bus.xfer_req_src_clk); end
    tests++; if (bus.xfer_data_src_clk !== 16'h1234) begin fails++; $display("FAIL stall_no_accept_on_match_data: got %h want 1234", bus.xfer_data_src_clk); end
    cyc();
    tests++; if (bus.xfer_req_src_clk !== 1'b1) begin fails++; $display("FAIL stall_idle_req: got %b want 1", bus.xfer_req_src_clk); end
    tests++; if (bus.xfer_count !== 16'h0001) begin fails++; $display("FAIL stall_count: got %h want 0001", bus.xfer_count); end
  endtask

  task automatic test_wrap();
    logic seen;
    do_reset();
    force dut.xfer_count_q = 16'hFFFF;
    repeat (2) cyc();
    release dut.xfer_count_q;
    cyc();
    tests++; if (bus.xfer_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h want ffff", bus.xfer_count); end
    bus.data_in = 16'h0007; bus.valid_in = 1'b1;
    cyc();
    bus.valid_in = 1'b0; ack_man = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc();
      if (bus.done_out === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL wrap_done_timeout: got %b want 1", seen); end
    tests++; if (bus.xfer_count !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h want 0000", bus.xfer_count); end
  endtask

  task automatic test_error_reset();
    do_reset();
    bus.data_in = 16'hC0DE; bus.valid_in = 1'b1;
    cyc();
    bus.valid_in = 1'b0;
    cyc();
    tests++; if (bus.xfer_req_src_clk !== 1'b1) begin fails++; $display("FAIL err_req_pending: got %b want 1", bus.xfer_req_src_clk); end
    rst = 1'b1;
    cyc();
    tests++; if (bus.ready_out !== 1'b0) begin fails++; $display("FAIL err_ready_in_rst: got %b want 0", bus.ready_out); end
    tests++; if (bus.xfer_req_src_clk !== 1'b0) begin fails++; $display("FAIL err_req_cleared: got %b want 0", bus.xfer_req_src_clk); end
    rst = 1'b0;
    #1;
    tests++; if (bus.ready_out !== 1'b1) begin fails++; $display("FAIL err_ready_after_rst: got %b want 1", bus.ready_out); end
    ack_man = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      tests++; if (bus.done_out !== 1'b0) begin fails++; $display("FAIL err_no_done edge%0d: got %b want 0", i, bus.done_out); end
      tests++; if (bus.proto_err !== (i == 3)) begin fails++; $display("FAIL err_proto edge%0d: got %b want %b", i, bus.proto_err, (i == 3)); end
    end
    repeat (2) cyc();
    tests++; if (bus.proto_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", bus.proto_err); end
    tests++; if (bus.xfer_count !== 16'h0000) begin fails++; $display("FAIL err_count: got %h want 0000", bus.xfer_count); end
    tests++; if (bus.ready_out !== 1'b1) begin fails++; $display("FAIL err_fsm_idle: got %b want 1", bus.ready_out); end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 16'h0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_error_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
